// File: rtl/keypad_scan_pkg.sv
// Shared types, key map and row-decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned N_ROWS = 4;
    localparam int unsigned N_COLS = 4;

    typedef enum logic {SCAN, HOLD} kp_state_t;

    // Indexed [row][col]; '*' maps to E and '#' to F.
    localparam logic [3:0] KEYMAP [N_ROWS][N_COLS] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic [1:0] first_low(input logic [N_ROWS-1:0] row);
        logic [1:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_ROWS; i++) begin
            if (!row[i] && !found) begin
                idx   = 2'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic logic multi_low(input logic [N_ROWS-1:0] row);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < N_ROWS; i++) begin
            if (!row[i]) n++;
        end
        return n > 1;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pin and key-report bundle between the scanner and its neighbours.
interface keypad_scan_if;
    import keypad_pkg::*;

    logic [N_ROWS-1:0] row;
    logic [N_COLS-1:0] col;
    logic              kphit;
    logic [3:0]        kpcode;

    modport master (input row, output col, output kphit, output kpcode);
    modport slave  (output row, input col, input kphit, input kpcode);
endinterface

// File: rtl/keypad_scan_sync2.sv
// Parameterised-width two-flop synchroniser with configurable reset value.
module sync2 #(
    parameter int unsigned     WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner; freezes on a press and reports an undebounced key.
// Optional multi-row rejection is enabled by defining KP_GHOST_REJECT_EN.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic          clk,
    input  logic          reset,
    keypad_scan_if.master kp
);
    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [N_ROWS-1:0] row_s;
    kp_state_t         state, state_nx;
    logic [CW-1:0]     div_cnt;
    logic [1:0]        cidx, cidx_nx;
    logic [1:0]        ridx, ridx_nx;
    logic [3:0]        code, code_nx;
    logic              hit;
    logic              sample;
    logic              ghost;

    sync2 #(.WIDTH(N_ROWS), .RESET_VAL(4'hF)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kp.row),
        .q     (row_s)
    );

    assign sample = (div_cnt == CW'(SCAN_DIV - 1));

`ifdef KP_GHOST_REJECT_EN
    assign ghost = multi_low(row_s);
`else
    assign ghost = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= SCAN;
            div_cnt <= '0;
            cidx    <= '0;
            ridx    <= '0;
            code    <= '0;
            hit     <= 1'b0;
        end else begin
            state   <= state_nx;
            div_cnt <= sample ? '0 : div_cnt + CW'(1);
            cidx    <= cidx_nx;
            ridx    <= ridx_nx;
            code    <= code_nx;
            hit     <= (state_nx == HOLD);
        end
    end

    always_comb begin
        state_nx = state;
        cidx_nx  = cidx;
        ridx_nx  = ridx;
        code_nx  = code;
        if (sample) begin
            unique case (state)
                SCAN: begin
                    if (row_s != 4'hF && !ghost) begin
                        state_nx = HOLD;
                        ridx_nx  = first_low(row_s);
                        code_nx  = KEYMAP[first_low(row_s)][cidx];
                    end else begin
                        cidx_nx = cidx + 2'd1;
                    end
                end
                HOLD: begin
                    // Only the latched row matters; other rows are ignored unless ghosting.
                    if (row_s[ridx] || ghost) begin
                        state_nx = SCAN;
                        cidx_nx  = cidx + 2'd1;
                    end
                end
                default: state_nx = SCAN;
            endcase
        end
    end

    assign kp.col    = ~(4'b0001 << cidx);
    assign kp.kphit  = hit;
    assign kp.kpcode = code;
endmodule

// File: tb/tb_keypad_scan.sv
// Randomised self-checking bench for keypad_scan against a cycle-level key-matrix model.
module tb_keypad_scan;
    localparam int unsigned N    = 8;
    localparam int          HALF = 5;

    logic        clk;
    logic        reset;
    logic [15:0] keys;
    logic [15:0] want_keys;
    logic [3:0]  row_drv;

    int unsigned n_tests;
    int unsigned n_fail;

    keypad_scan_if kp_if ();

    keypad_scan #(.SCAN_DIV(N)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp_if)
    );

    initial clk = 1'b0;
    always #HALF clk = ~clk;

    // Physical matrix: a closed key shorts its row to its column's level.
    always_comb begin
        row_drv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kp_if.col[c]) row_drv[r] = 1'b0;
    end
    assign kp_if.row = row_drv;

    // Reference model state
    string       legend = "123A456B789CE0FD";
    int unsigned m_div;
    int          m_col;
    int          m_ridx;
    bit          m_hold;
    logic [3:0]  m_code;
    logic [3:0]  p1, p2;

    function automatic logic [3:0] key_value(int r, int c);
        byte ch;
        ch = legend[r*4+c];
        return (ch >= "A") ? 4'(ch - "A" + 10) : 4'(ch - "0");
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_div  = 0;
        m_col  = 0;
        m_ridx = 0;
        m_hold = 0;
        m_code = 4'h0;
        p1     = 4'hF;
        p2     = 4'hF;
    endtask

    task automatic model_step();
        logic [3:0] pins;
        logic [3:0] rs;
        int         nlow;
        int         low0;
        pins = 4'hF;
        for (int r = 0; r < 4; r++)
            if (keys[r*4+m_col]) pins[r] = 1'b0;
        rs   = p2;
        nlow = 0;
        low0 = -1;
        for (int r = 0; r < 4; r++)
            if (!rs[r]) begin
                nlow++;
                if (low0 < 0) low0 = r;
            end
        if (m_div == N - 1) begin
            if (!m_hold) begin
`ifdef KP_GHOST_REJECT_EN
                if (nlow == 1) begin
`else
                if (nlow >= 1) begin
`endif
                    m_hold = 1;
                    m_ridx = low0;
                    m_code = key_value(low0, m_col);
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end else begin
`ifdef KP_GHOST_REJECT_EN
                if (rs[m_ridx] || nlow > 1) begin
`else
                if (rs[m_ridx]) begin
`endif
                    m_hold = 0;
                    m_col  = (m_col + 1) % 4;
                end
            end
        end
        p2    = p1;
        p1    = pins;
        m_div = (m_div + 1) % N;
    endtask

    task automatic check_outputs();
        check("col",    32'(kp_if.col),    32'(4'hF ^ (4'h1 << m_col)));
        check("kphit",  32'(kp_if.kphit),  32'(m_hold));
        check("kpcode", 32'(kp_if.kpcode), 32'(m_code));
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            check_outputs();
            keys = want_keys;
            model_step();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_kphit", 32'(kp_if.kphit), 32'h0);
        check("rst_col",   32'(kp_if.col),   32'hE);
        check("rst_code",  32'(kp_if.kpcode), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_outputs();
        keys = want_keys;
        model_step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        keys      = '0;
        want_keys = '0;
        model_reset();

        do_reset();
        cycles(40);
        check("idle_code", 32'(kp_if.kpcode), 32'h0);

        want_keys = 16'(1) << (1*4+2);
        cycles(40);
        check("k12_hit",  32'(kp_if.kphit),  32'h1);
        check("k12_code", 32'(kp_if.kpcode), 32'h6);
        check("k12_col",  32'(kp_if.col),    32'hB);
        want_keys = '0;
        cycles(20);
        check("k12_rel", 32'(kp_if.kphit), 32'h0);

        want_keys = 16'(1) << (3*4+1);
        cycles(40);
        want_keys = want_keys | (16'(1) << (0*4+1));
        cycles(40);
        check("k31_hit",  32'(kp_if.kphit),  32'h1);
        check("k31_code", 32'(kp_if.kpcode), 32'h0);
        want_keys = 16'(1) << (0*4+1);
        cycles(40);
        want_keys = '0;
        cycles(20);

        want_keys = (16'(1) << 0) | (16'(1) << (2*4+0));
        cycles(40);
`ifdef KP_GHOST_REJECT_EN
        check("ghost_hit", 32'(kp_if.kphit), 32'h0);
`else
        check("multi_code", 32'(kp_if.kpcode), 32'h1);
`endif
        want_keys = '0;
        cycles(20);

        want_keys = 16'(1) << (2*4+3);
        cycles(40);
        check("k23_hit", 32'(kp_if.kphit), 32'h1);
        do_reset();
        cycles(34);
        check("k23_code", 32'(kp_if.kpcode), 32'hC);
        want_keys = '0;
        cycles(20);

        for (int it = 0; it < 80; it++) begin
            want_keys = '0;
            repeat ($urandom_range(0, 2)) want_keys[$urandom_range(0, 15)] = 1'b1;
            cycles($urandom_range(1, 30));
        end
        want_keys = '0;
        cycles(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Keypad scanner for the room terminal's 4x4 matrix keypad. Drives one column low at a time and samples the four pulled-up row lines. On a key press it freezes the scan and asserts `kphit` with a stable key code. `kphit` is the raw, undebounced request the keypad debouncer consumes; `kpcode` is held valid for as long as `kphit` is high.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles each column is driven (dwell). Legal range 4..2^20.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `row`  in  4  keypad rows, active-low, externally pulled up; asynchronous to `clk`.
- `col`  out  4  keypad column drive, active-low, one-cold.
- `kphit`  out  1  high while a key is held (undebounced).
- `kpcode`  out  4  mapped key value; valid while `kphit`=1, holds its last value otherwise.

## Operation
- `row` passes through a 2-flop synchroniser before any use (`row_s`).
- Dwell counter `div_cnt` counts 0..SCAN_DIV-1, then wraps. Sample point: the cycle where `div_cnt`==SCAN_DIV-1.
- Column index `cidx` (2 bits) selects the driven column: `col` = ~(4'b0001 << cidx).
- States:
  - SCAN: at each sample point, if `row_s` != 4'hF, latch `ridx` (lowest-numbered low row wins), latch `kpcode` = KEYMAP[ridx][cidx], go HOLD. Otherwise `cidx` <= `cidx`+1 (wraps 3->0), stay in SCAN.
  - HOLD: `cidx` frozen, `kphit`=1. At each sample point, if `row_s[ridx]` is 1 (released), go SCAN and advance `cidx`. Otherwise stay in HOLD. Other rows changing while in HOLD are ignored.
- KEYMAP is indexed [row][col]:
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: E(*),0,F(#),D
- `kphit` is registered and equals (state==HOLD).

## Timing
- Reset values:
  - state = SCAN, `cidx`=0, `col`=4'b1110
  - `div_cnt`=0, `kphit`=0, `kpcode`=4'h0, `ridx`=0
  - synchroniser flops = 4'hF
- Sync latency: 2 cycles from a pin change to `row_s`.
- Press latency: a row low at the pins at least 3 cycles before a sample point raises `kphit`, and updates `kpcode`, on the cycle after that sample point.
- Release latency: the same rule; `kphit` falls on the cycle after the first sample point that sees the row high.
- `col` advances on the cycle after the sample point. Each column is driven for exactly SCAN_DIV cycles while in SCAN.
- A press and a release inside one dwell window, with no sample point between them, produces no `kphit`.
- Reset mid-HOLD drops `kphit` immediately (asynchronous) and restarts the scan at column 0.

## Configuration
- `KP_GHOST_REJECT_EN` defined:
  - In SCAN, a sample with more than one low row in the driven column is treated as no key; the scan advances.
  - In HOLD, a sample with more than one low row releases the key (go SCAN).
- `KP_GHOST_REJECT_EN` undefined: lowest-index low row wins; multiple low rows are not checked.

## Structure
- Package `keypad_pkg` holds:
  - `typedef enum logic {SCAN, HOLD} kp_state_t`
  - `KEYMAP` constant array [4][4] of logic[3:0]
  - `N_ROWS`=4, `N_COLS`=4
- Sub-module `sync2`: parameterised-width 2-flop synchroniser, with reset value parameter (4'hF here).

## Test plan
Benches use SCAN_DIV=8 and a keypad model that ties row r to column c's level when key (r,c) is closed.
- Reset release, no key: `col` cycles 1110->1101->1011->0111->1110, 8 cycles per step; `kphit`=0; `kpcode`=0.
- Close key (1,2): `kphit` rises on the cycle after column 2's sample point; `kpcode`=4'h6; `col` stays 1011 while held.
- Release key (1,2): `kphit` falls on the cycle after the next sample point; `col` goes to 0111 on that same cycle.
- Close (3,1) then (0,1) while (3,1) is held: `kpcode` stays 4'h0; `kphit` stays high until (3,1) opens.
- Close (0,0) and (2,0) together:
  - Macro undefined: `kpcode`=4'h1.
  - `KP_GHOST_REJECT_EN` defined: `kphit` stays 0.
- Assert `reset` during HOLD on key (2,3): `kphit`=0 and `col`=1110 the same cycle. After release of reset with the key still closed, `kpcode`=4'hC on the first column-3 sample.
